imem_boot_loader: RTL and testbench

- Upstream feeder of the in-order single-issue core. Streams a program into the fetch stage's instruction memory through a valid/ready word interface.
- Pads the unused tail of the memory with NOPs.
- Holds the core in reset until the image is complete, then releases it.
- Replaces hierarchical testbench preloads with a synthesizable boot path. Sits between the host/bench and proc_top (the imem write port and the core reset).

---
 rtl/imem_boot_loader_if.sv | 35 +++
 rtl/imem_boot_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//   Word-stream load channel from the host/bench into imem_boot_loader.
//   One 32-bit instruction word moves per cycle when ld_valid && ld_ready.
//
// Signals:
//   ld_valid  host -> loader  word on ld_data is valid
//   ld_data   host -> loader  instruction word
//   ld_last   host -> loader  word is the final word of the image
//   ld_ready  loader -> host  loader accepts a word this cycle
//
// Modports:
//   master  host side (drives valid/data/last, observes ready)
//   slave   loader side (observes valid/data/last, drives ready)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Synthesizable boot path for the in-order core. Streams a program image
//   from the host into the fetch-stage instruction memory, pads the unused
//   tail of the memory with NOP_WORD, and holds the core in reset until the
//   whole memory has been written plus RELEASE_DLY settle cycles.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   When defined, a 32-bit wrap-around sum of every accepted word is kept
//   and compared with exp_sum when leaving HOLD; a mismatch parks the loader
//   in ERR with the core held in reset. When undefined, exp_sum is unused
//   and err only reports an image that overflowed the memory.
//
// Ports:
//   clk          core clock
//   resetn       asynchronous active-low reset
//   ld           load channel (slave modport): ld_valid/ld_data/ld_last in,
//                ld_ready out
//   reload       single-cycle request to re-enter LOAD; honoured only in RUN
//   exp_sum      expected image checksum (BOOT_CHECKSUM_EN only)
//   imem_we      instruction memory write enable
//   imem_addr    instruction memory word address
//   imem_wdata   instruction memory write data
//   core_resetn  active-low reset to proc_top
//   done         image loaded and core running
//   err          sticky error (overflow, or checksum mismatch)
//   word_count   words accepted from the host in the current load
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int          DEPTH       = 256,
  parameter int          ADDR_W      = $clog2(DEPTH),
  parameter int          RELEASE_DLY = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                clk,
  input  logic                resetn,
  imem_boot_loader_if.slave   ld,
  input  logic                reload,
  input  logic [31:0]         exp_sum,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                core_resetn,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
);

  // HOLD counts 0 .. RELEASE_DLY-1, so it needs clog2(RELEASE_DLY) bits
  // (at least one).
  localparam int HOLD_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_DLY - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_FILL = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t              state_reg;
  logic                ld_ready_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_addr_reg;
  logic [31:0]         imem_wdata_reg;
  logic                core_resetn_reg;
  logic                done_reg;
  logic                err_reg;
  logic [ADDR_W:0]     word_count_reg;
  logic [ADDR_W-1:0]   fill_addr_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0]         sum_reg;
`else
  // exp_sum has no consumer in this build; fold it into a named sink.
  logic                unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
`endif

  // ld_ready is only ever high in LOAD, so it doubles as the state qualifier
  // for the handshake.
  logic              accept;
  logic [ADDR_W-1:0] load_idx;
  logic              at_top;

  assign accept   = ld_ready_reg && ld.ld_valid;
  // While loading, word_count never exceeds DEPTH-1, so its low bits are the
  // address of the word being accepted.
  assign load_idx = word_count_reg[ADDR_W-1:0];
  assign at_top   = (load_idx == LAST_ADDR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_LOAD;
      ld_ready_reg    <= 1'b1;
      imem_we_reg     <= 1'b0;
      imem_addr_reg   <= '0;
      imem_wdata_reg  <= '0;
      core_resetn_reg <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      word_count_reg  <= '0;
      fill_addr_reg   <= '0;
      hold_cnt_reg    <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_reg         <= '0;
`endif
    end else begin
      // Write strobe is a one-cycle pulse unless a state re-asserts it.
      imem_we_reg <= 1'b0;

      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            imem_we_reg    <= 1'b1;
            imem_addr_reg  <= load_idx;
            imem_wdata_reg <= ld.ld_data;
            word_count_reg <= word_count_reg + WC_ONE;
`ifdef BOOT_CHECKSUM_EN
            sum_reg        <= sum_reg + ld.ld_data;
`endif
            if (ld.ld_last || at_top) begin
              ld_ready_reg <= 1'b0;
              hold_cnt_reg <= '0;
              if (at_top) begin
                // Memory is full: nothing left to pad. A full memory without
                // ld_last means the host had more to send; flag it but keep
                // booting what fits.
                state_reg <= ST_HOLD;
                if (!ld.ld_last) begin
                  err_reg <= 1'b1;
                end
              end else begin
                state_reg     <= ST_FILL;
                fill_addr_reg <= load_idx + ADDR_ONE;
              end
            end
          end
        end

        ST_FILL: begin
          imem_we_reg    <= 1'b1;
          imem_addr_reg  <= fill_addr_reg;
          imem_wdata_reg <= NOP_WORD;
          if (fill_addr_reg == LAST_ADDR) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
          end else begin
            fill_addr_reg <= fill_addr_reg + ADDR_ONE;
          end
        end

        ST_HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
`ifdef BOOT_CHECKSUM_EN
            if (sum_reg != exp_sum) begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
            end else begin
              state_reg       <= ST_RUN;
              core_resetn_reg <= 1'b1;
              done_reg        <= 1'b1;
            end
`else
            state_reg       <= ST_RUN;
            core_resetn_reg <= 1'b1;
            done_reg        <= 1'b1;
`endif
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_ONE;
          end
        end

        ST_RUN: begin
          // err stays sticky across a reload; only resetn clears it.
          if (reload) begin
            state_reg       <= ST_LOAD;
            core_resetn_reg <= 1'b0;
            done_reg        <= 1'b0;
            word_count_reg  <= '0;
            ld_ready_reg    <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            sum_reg         <= '0;
`endif
          end
        end

        ST_ERR: begin
          ld_ready_reg    <= 1'b0;
          core_resetn_reg <= 1'b0;
          done_reg        <= 1'b0;
        end

        default: begin
          // Unused encodings: park with the core held in reset.
          state_reg       <= ST_ERR;
          ld_ready_reg    <= 1'b0;
          core_resetn_reg <= 1'b0;
          done_reg        <= 1'b0;
        end
      endcase
    end
  end

  assign ld.ld_ready  = ld_ready_reg;
  assign imem_we      = imem_we_reg;
  assign imem_addr    = imem_addr_reg;
  assign imem_wdata   = imem_wdata_reg;
  assign core_resetn  = core_resetn_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign word_count   = word_count_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader (DEPTH=16, RELEASE_DLY=2).
//   Expected memory images, write timing, release cycle and status are
//   derived from the load rules: words 0..N-1 land one cycle after their
//   accept, NOPs fill N..DEPTH-1 on consecutive cycles after the last word,
//   and the core is released DEPTH-N+1+RELEASE_DLY cycles after the last
//   accept.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;
  localparam int          DEPTH       = 16;
  localparam int          ADDR_W      = 4;
  localparam int          RELEASE_DLY = 2;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic              clk;
  logic              resetn;
  logic              reload;
  logic [31:0]       exp_sum;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_resetn;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  imem_boot_loader_if lb ();

  imem_boot_loader #(
    .DEPTH       (DEPTH),
    .RELEASE_DLY (RELEASE_DLY),
    .NOP_WORD    (NOP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ld          (lb),
    .reload      (reload),
    .exp_sum     (exp_sum),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_resetn (core_resetn),
    .done        (done),
    .err         (err),
    .word_count  (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          err_exp  = 1'b0;
  int          wq_cyc[$];
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          acc_q[$];
  bit          rel_seen;
  int          rel_cyc;
  logic [31:0] img_w [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, expv, expv);
    end
  endtask

  // Sample outputs on the falling edge, then advance past the next rising
  // edge. Inputs are driven by the caller after this returns.
  task automatic tick();
    @(negedge clk);
    if (imem_we) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
    if (lb.ld_valid && lb.ld_ready) acc_q.push_back(cyc);
    if (core_resetn && !rel_seen) begin
      rel_seen = 1'b1;
      rel_cyc  = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ready"},  32'(lb.ld_ready),   1);
    check({pfx, "_we"},     32'(imem_we),       0);
    check({pfx, "_addr"},   32'(imem_addr),     0);
    check({pfx, "_wdata"},  imem_wdata,         0);
    check({pfx, "_coreRn"}, 32'(core_resetn),   0);
    check({pfx, "_done"},   32'(done),          0);
    check({pfx, "_err"},    32'(err),           0);
    check({pfx, "_wc"},     32'(word_count),    0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_coreRn", 32'(core_resetn), 0);
    check("reload_done",   32'(done),        0);
    check("reload_ready",  32'(lb.ld_ready), 1);
    check("reload_wc",     32'(word_count),  0);
    check("reload_err",    32'(err),         32'(err_exp));
  endtask

  // Load img_w[0..n-1]; expects the loader to be in LOAD on entry.
  task automatic do_load(input int n, input bit with_last, input bit bubbles,
                         input bit noise, input bit bad_sum);
    logic [31:0] sum;
    logic [31:0] exp_img [DEPTH];
    int t;
    int guard;
    int idle;
    int exp_c;
    wq_cyc.delete();
    wq_addr.delete();
    wq_data.delete();
    acc_q.delete();
    rel_seen = 1'b0;
    rel_cyc  = -1;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) exp_img[i] = (i < n) ? img_w[i] : NOP;
    for (int i = 0; i < n; i++) sum = sum + img_w[i];
    exp_sum = bad_sum ? sum + 32'd1 : sum;
    if (n == DEPTH && !with_last) err_exp = 1'b1;
    if (bad_sum) err_exp = 1'b1;

    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        idle = int'($urandom_range(1, 2));
        for (int b = 0; b < idle; b++) begin
          lb.ld_valid = 1'b0;
          lb.ld_data  = $urandom;
          lb.ld_last  = 1'($urandom_range(0, 1));
          reload      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
      end
      lb.ld_valid = 1'b1;
      lb.ld_data  = img_w[i];
      lb.ld_last  = with_last && (i == n - 1);
      reload      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      guard = 0;
      while (acc_q.size() <= i && guard < 8) begin
        tick();
        guard++;
      end
    end
    lb.ld_valid = 1'b0;
    lb.ld_last  = 1'b0;
    reload      = 1'b0;
    check("accepts", acc_q.size(), n);
    check("ready_drop", 32'(lb.ld_ready), 0);
    t = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : cyc;

    guard = 0;
    while (!rel_seen && guard < DEPTH + RELEASE_DLY + 10) begin
      tick();
      guard++;
    end

    check("wr_count", wq_addr.size(), DEPTH);
    for (int j = 0; j < wq_addr.size(); j++) begin
      if (j < n) exp_c = (j < acc_q.size()) ? acc_q[j] + 1 : -1;
      else       exp_c = t + j - n + 2;
      check($sformatf("wr_addr[%0d]", j), 32'(wq_addr[j]), j);
      check($sformatf("wr_data[%0d]", j), wq_data[j], (j < DEPTH) ? exp_img[j] : 32'hx);
      check($sformatf("wr_cyc[%0d]", j),  wq_cyc[j], exp_c);
    end

    if (!bad_sum) begin
      check("release_cyc", rel_cyc, t + DEPTH - n + 1 + RELEASE_DLY);
      check("run_coreRn",  32'(core_resetn), 1);
      check("run_done",    32'(done),        1);
      check("run_wc",      32'(word_count),  n);
    end else begin
      check("err_norelease", 32'(rel_seen), 0);
      check("err_coreRn",    32'(core_resetn), 0);
      check("err_done",      32'(done),        0);
    end
    check("end_ready", 32'(lb.ld_ready), 0);
    check("end_err",   32'(err),         32'(err_exp));
    $display("load n=%0d last=%0d bubbles=%0d noise=%0d bad_sum=%0d last_acc=%0d writes=%0d release=%0d",
             n, with_last, bubbles, noise, bad_sum, t, wq_addr.size(), rel_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    bit lst;
    resetn      = 1'b0;
    reload      = 1'b0;
    exp_sum     = '0;
    lb.ld_valid = 1'b0;
    lb.ld_data  = '0;
    lb.ld_last  = 1'b0;
    rel_seen    = 1'b0;
    rel_cyc     = -1;
    tick();
    tick();
    check_reset_vals("rst");
    resetn = 1'b1;
    tick();
    check_reset_vals("post_rst");

    // Swap program, back to back.
    img_w[0] = 32'h01908093; img_w[1] = 32'h04b10113; img_w[2] = 32'h002080b3;
    img_w[3] = 32'h40208133; img_w[4] = 32'h402080b3; img_w[5] = 32'hffd08093;
    do_load(6, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bubbles between beats.
    do_reload();
    for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
    do_load(4, 1'b1, 1'b1, 1'b0, 1'b0);

    // Overflow: full memory with no ld_last.
    do_reload();
    for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
    do_load(DEPTH, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reload after overflow: err stays set.
    do_reload();
    for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
    do_load(2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized loads with reload noise outside RUN.
    for (int r = 0; r < 6; r++) begin
      do_reload();
      for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
      n   = int'($urandom_range(1, DEPTH));
      lst = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      do_load(n, lst, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of FILL.
    do_reload();
    lb.ld_valid = 1'b1; lb.ld_data = $urandom; lb.ld_last = 1'b0;
    tick();
    lb.ld_data = $urandom; lb.ld_last = 1'b1;
    tick();
    lb.ld_valid = 1'b0; lb.ld_last = 1'b0;
    tick();
    tick();
    check("midfill_we", 32'(imem_we), 1);
    #2 resetn = 1'b0;
    #1 check_reset_vals("async_rst");
    err_exp = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("rst_exit_ready", 32'(lb.ld_ready), 1);
    check("rst_exit_addr",  32'(imem_addr),   0);
    for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
    do_load(3, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    do_reload();
    img_w[0] = 32'h00000001; img_w[1] = 32'h00000002;
    do_load(2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reload();
    do_load(2, 1'b1, 1'b0, 1'b0, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tick();
    check("err_absorb_coreRn", 32'(core_resetn), 0);
    check("err_absorb_ready",  32'(lb.ld_ready), 0);
    check("err_absorb_err",    32'(err),         1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
